pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer for the core's fetch stage. Owns the PC register, steps it on each retired instruction, and redirects it through a writable 8-entry absolute jump-target table on taken branches. Runs the program from a start pulse to a halt and reports completion to the top level. The table resets to the program's standard labels and can be reconfigured between runs.

## Interface
Parameters:
- D, 8, PC width in bits.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock; dominates every other input.
- start  in  1  launch the program from PC 0; honoured only in IDLE or DONE.
- stall  in  1  hold the current instruction; the instruction does not retire.
- halt  in  1  decoded halt instruction at the current PC.
- branch  in  1  taken branch at the current PC.
- idx  in  3  jump-table index for `branch`.
- cfg_we  in  1  jump-table write enable; honoured only in IDLE or DONE.
- cfg_idx  in  3  jump-table write index.
- cfg_target  in  D  jump-table write data.
- prog_ctr  out  D  current PC (registered).
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next start.
- fault  out  1  high in DONE if the run ended by PC overflow instead of halt.
- instr_count  out  CNT_W  instructions retired in the current or last run; saturates at all-ones.

## Operation
- States: IDLE, RUN, DONE.
- On reset: state IDLE, prog_ctr=0, busy=0, done=0, fault=0, instr_count=0. The table loads defaults 17, 22, 24, 31, 35, 44, 46, 64 for entries 0..7.
- IDLE/DONE + start: go to RUN, prog_ctr=0, instr_count=0, fault=0.
- In IDLE or DONE, all other inputs except cfg_* are ignored.
- RUN, priority stall > halt > branch > step:
  - stall: all state holds, including prog_ctr and instr_count.
  - halt: go to DONE, prog_ctr holds, instr_count+1. The halt instruction retires.
  - branch: prog_ctr=table[idx], instr_count+1.
  - step: prog_ctr+1, instr_count+1.
- Overflow: a step at prog_ctr=2^D-1 goes to DONE with fault=1, prog_ctr holds at 2^D-1, and instr_count+1. The PC never wraps to 0.
- The branch path has no overflow check. A target of 0 is legal.
- start in RUN is ignored. A restart requires DONE.
- cfg_we in IDLE/DONE: table[cfg_idx]=cfg_target at the edge. cfg_we in RUN is ignored and the table is unchanged.
- cfg_we and start in the same cycle: both take effect. The new entry is visible from the first RUN cycle.
- The table read is combinational. A branch sampled at edge N uses the table contents present during cycle N.
- instr_count saturates at 2^CNT_W-1.

## Timing
- All outputs are registered. The effective latency is one edge for every transition.
- start sampled at edge k: busy=1 and prog_ctr=0 after edge k. The first instruction is at PC 0 in cycle k+1.
- branch sampled at edge k: prog_ctr=target after edge k.
- halt sampled at edge k: done=1 and busy=0 after edge k. done is never high in the same cycle as halt.
- busy and done are never both high.
- Reset asserted mid-RUN returns everything to reset values at that edge. This includes the table, which reverts to its defaults.
- Back-to-back runs: start may be asserted in the first DONE cycle.

## Structure
- Package `pc_seq_pkg` holds:
  - the `state_t` enum (IDLE, RUN, DONE);
  - the constant `JT_DEFAULT[8]` with the default targets;
  - the table-depth localparam (8).
- Sub-module `jump_table`:
  - 8×D register file with synchronous reset to `JT_DEFAULT`;
  - one synchronous write port and one combinational read port.
- `pc_sequencer` contains the FSM, the PC register, the counter, and the write-gating logic.

## Test plan
- Reset, then start; no branch, halt or stall for 5 cycles, then halt → prog_ctr 0,1,2,3,4,5 and held at 5. done=1 one cycle after halt; instr_count=6, fault=0.
- RUN, branch with idx=3 at PC 2 → prog_ctr=31 the next cycle. With idx=7 → 64. stall+branch in the same cycle → PC and count unchanged.
- In DONE, cfg_we with cfg_idx=1 and cfg_target=0xA0, plus start in the same cycle; then branch idx=1 → prog_ctr=0xA0. cfg_we during RUN → entry unchanged, read back via branch.
- Branch to target 0xFE, then step twice → prog_ctr=0xFF, then DONE with fault=1 and prog_ctr=0xFF.
- Reset mid-RUN after a table write → prog_ctr=0, IDLE, busy=0. Branch idx=1 after restart → 22.
- halt+branch in the same cycle → DONE, PC unchanged. start pulse while busy → no effect on prog_ctr or instr_count.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

  localparam int unsigned JT_DEPTH = 8;
  localparam int unsigned JT_IDX_W = $clog2(JT_DEPTH);
  localparam int unsigned JT_DEF_W = 8;

  // Standard program labels; element 0 sits in the least-significant slot.
  localparam logic [JT_DEPTH-1:0][JT_DEF_W-1:0] JT_DEFAULT = {
    8'd64, 8'd46, 8'd44, 8'd35, 8'd31, 8'd24, 8'd22, 8'd17
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch-stage controller and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned D     = 8,
  parameter int unsigned CNT_W = 16
) ();
  import pc_seq_pkg::*;

  logic                start;
  logic                stall;
  logic                halt;
  logic                branch;
  logic [JT_IDX_W-1:0] idx;
  logic                cfg_we;
  logic [JT_IDX_W-1:0] cfg_idx;
  logic [D-1:0]        cfg_target;
  logic [D-1:0]        prog_ctr;
  logic                busy;
  logic                done;
  logic                fault;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    output start, stall, halt, branch, idx, cfg_we, cfg_idx, cfg_target,
    input  prog_ctr, busy, done, fault, instr_count
  );

  modport slave (
    input  start, stall, halt, branch, idx, cfg_we, cfg_idx, cfg_target,
    output prog_ctr, busy, done, fault, instr_count
  );

endinterface

// File: rtl/pc_sequencer_jump_table.sv
// 8-entry absolute jump-target register file: one sync write port, one comb read port.
module jump_table
  import pc_seq_pkg::*;
#(
  parameter int unsigned D = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [JT_IDX_W-1:0] widx,
  input  logic [D-1:0]        wdata,
  input  logic [JT_IDX_W-1:0] ridx,
  output logic [D-1:0]        rdata_c
);

  logic [D-1:0] entries [JT_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < JT_DEPTH; i++) begin
        entries[i[JT_IDX_W-1:0]] <= D'(JT_DEFAULT[i[JT_IDX_W-1:0]]);
      end
    end else if (we) begin
      entries[widx] <= wdata;
    end
  end

  assign rdata_c = entries[ridx];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: start-to-halt run control, PC stepping/branching, retire counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned D     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [D-1:0]     target_c;
  logic             jt_we_c;

  // Table is only writable while no program is running.
  assign jt_we_c = bus.cfg_we && (state_q != RUN);

  jump_table #(.D(D)) u_jump_table (
    .clk     (clk),
    .reset   (reset),
    .we      (jt_we_c),
    .widx    (bus.cfg_idx),
    .wdata   (bus.cfg_target),
    .ridx    (bus.idx),
    .rdata_c (target_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          // Every non-stalled cycle retires exactly one instruction.
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (bus.halt) begin
            state_d = DONE;
          end else if (bus.branch) begin
            pc_d = target_c;
          end else if (pc_q == '1) begin
            state_d = DONE;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;
  assign bus.instr_count = cnt_q;

endmodule
